fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one `fifo_mem` write port among `NUM_REQ` producers. It drives the FIFO's `trans_write`/`data_in` directly and uses the FIFO's `full_ind` and `threshold_ind` for backpressure and fairness. It bounds each requester's burst length and counts accepted writes. It sits between the producer blocks and the single FIFO instance.

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_mem write port among NUM_REQ producers,
// with bounded bursts, full/threshold backpressure and an accepted-beat counter.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int BURST_MAX  = 4,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   input  logic                          fifo_threshold,
   output logic                          trans_write,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic                          owner_valid,
   output logic [ID_WIDTH-1:0]           owner_id,
   output logic [15:0]                   write_count
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam logic [3:0]          BURST_LAST      = 4'(BURST_MAX);
   localparam logic [ID_WIDTH-1:0] LAST_OWNER_INIT = ID_WIDTH'(NUM_REQ - 1);

   state_t                state_reg, state_next;
   logic [ID_WIDTH-1:0]   owner_reg, owner_next;
   logic [ID_WIDTH-1:0]   last_owner_reg, last_owner_next;
   logic [3:0]            beats_reg, beats_next;
   logic [15:0]           write_count_reg, write_count_next;

   logic [ID_WIDTH-1:0]   winner;
   logic                  any_req;
   logic                  owner_req;
   logic                  accept;
   logic                  burst_done;
   logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign any_req    = |req;
   assign owner_req  = req[owner_reg];
   assign accept     = (state_reg == OWN) && owner_req && !fifo_full;
   // Threshold caps the burst at the current beat so producers share a nearly-full FIFO.
   assign burst_done = ((beats_reg + 4'd1) == BURST_LAST) || fifo_threshold;

   // Search starts just after the previous owner so every requester eventually wins.
   always_comb begin
      int  idx;
      logic found;
      winner = last_owner_reg;
      found  = 1'b0;
      idx    = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_owner_reg) + off) % NUM_REQ;
         if (!found && req[idx]) begin
            winner = ID_WIDTH'(idx);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         owner_reg       <= '0;
         last_owner_reg  <= LAST_OWNER_INIT;
         beats_reg       <= '0;
         write_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         owner_reg       <= owner_next;
         last_owner_reg  <= last_owner_next;
         beats_reg       <= beats_next;
         write_count_reg <= write_count_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      owner_next       = owner_reg;
      last_owner_next  = last_owner_reg;
      beats_next       = beats_reg;
      write_count_next = write_count_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next      = OWN;
               owner_next      = winner;
               last_owner_next = winner;
               beats_next      = '0;
            end
         end
         OWN: begin
            if (accept) begin
               beats_next       = beats_reg + 4'd1;
               write_count_next = write_count_reg + 16'd1;
               if (burst_done) begin
                  state_next = IDLE;
               end
            end else if (!owner_req && !fifo_full) begin
               // Owner released its request; a full FIFO instead holds the grant in place.
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gnt         = '0;
      trans_write = 1'b0;
      fifo_data   = '0;
      owner_valid = (state_reg == OWN);
      if (accept) begin
         gnt[owner_reg] = 1'b1;
         trans_write    = 1'b1;
         fifo_data      = req_data_arr[owner_reg];
      end
   end

   assign owner_id    = owner_reg;
   assign write_count = write_count_reg;

endmodule
